// File: rtl/proc_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and requester identifiers.
package proc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction/data requester handshakes and the shared memory port.
// The master side owns the requests and the memory read data; the slave side is the arbiter.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
);

   logic              i_req;
   logic              i_we;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_wdata;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ack;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output i_req, i_we, i_addr, i_wdata,
      input  i_rdata, i_ack,
      output d_req, d_we, d_addr, d_wdata,
      input  d_rdata, d_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  i_req, i_we, i_addr, i_wdata,
      output i_rdata, i_ack,
      input  d_req, d_we, d_addr, d_wdata,
      output d_rdata, d_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a conflict goes to the port not granted last.
module rr_pick2
   import proc_pkg::*;
(
   input  logic     reqI,
   input  logic     reqD,
   input  port_id_t lastGrant,
   output logic     grantValid_c,
   output port_id_t grantId_c
);

   always_comb begin
      grantValid_c = reqI | reqD;
      grantId_c    = PORT_I;
      if (reqI && reqD) begin
         grantId_c = (lastGrant == PORT_I) ? PORT_D : PORT_I;
      end else if (reqD) begin
         grantId_c = PORT_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction and data requesters,
// sequencing the enable/wait states and returning read data with a one-cycle ack.
module mem_port_arbiter
   import proc_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus,
   output logic               busy,
   output logic               last_grant
);

   localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

   if (MEM_LAT < 1) begin : gLatCheck
      $error("mem_port_arbiter: MEM_LAT must be >= 1");
   end

   arb_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic              iMask;
   logic              dMask;
   port_id_t          lastGrant;

   logic              grantValid_c;
   port_id_t          grantId_c;
   logic              selWe_c;
   logic [ADDR_W-1:0] selAddr_c;
   logic [DATA_W-1:0] selWdata_c;

   // A port just acked stays masked for one IDLE cycle so its still-held req is not re-granted.
   rr_pick2 uPick (
      .reqI         (bus.i_req & ~iMask),
      .reqD         (bus.d_req & ~dMask),
      .lastGrant    (lastGrant),
      .grantValid_c (grantValid_c),
      .grantId_c    (grantId_c)
   );

   always_comb begin
      selWe_c    = bus.i_we;
      selAddr_c  = bus.i_addr;
      selWdata_c = bus.i_wdata;
      if (grantId_c == PORT_D) begin
         selWe_c    = bus.d_we;
         selAddr_c  = bus.d_addr;
         selWdata_c = bus.d_wdata;
      end
   end

   assign last_grant = lastGrant;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         iMask         <= 1'b0;
         dMask         <= 1'b0;
         lastGrant     <= PORT_I;
         busy          <= 1'b0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.i_rdata   <= '0;
         bus.d_rdata   <= '0;
         bus.i_ack     <= 1'b0;
         bus.d_ack     <= 1'b0;
      end else begin
         bus.i_ack <= 1'b0;
         bus.d_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               iMask <= 1'b0;
               dMask <= 1'b0;
               if (grantValid_c) begin
                  lastGrant     <= grantId_c;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= selWe_c;
                  bus.mem_addr  <= selAddr_c;
                  bus.mem_wdata <= selWdata_c;
                  cnt           <= CNT_W'(MEM_LAT - 1);
                  busy          <= 1'b1;
                  state         <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  if (lastGrant == PORT_I) begin
                     if (!bus.mem_we) bus.i_rdata <= bus.mem_rdata;
                     bus.i_ack <= 1'b1;
                     iMask     <= 1'b1;
                  end else begin
                     if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
                     bus.d_ack <= 1'b1;
                     dMask     <= 1'b1;
                  end
                  bus.mem_en <= 1'b0;
                  bus.mem_we <= 1'b0;
                  state      <= RESP;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: MEM_LAT=2 instance for the main scenarios,
// MEM_LAT=1 instance for the single-cycle access case.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy0, lg0, busy1, lg1;
   int   cyc  = 0;
   int   nVec = 0;
   int   nMis = 0;

   typedef struct {
      logic [63:0] rdata;
      int          ackCyc;
   } exp_t;

   exp_t iQ[$];
   exp_t dQ[$];
   exp_t i1Q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus0 ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus1 ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(2)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .last_grant(lg0)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .last_grant(lg1)
   );

   // Memory contents: a fixed pattern per address, with one known word at 0x100.
   function automatic logic [63:0] memData(input logic [31:0] a);
      return (a == 32'h100) ? 64'hDEAD_BEEF : {a, ~a};
   endfunction

   assign bus0.mem_rdata = memData(bus0.mem_addr);
   assign bus1.mem_rdata = memData(bus1.mem_addr);

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nVec++;
      if (got !== exp) begin
         nMis++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Ack monitor: every ack must match the oldest queued expectation in cycle and data.
   always @(negedge clk) begin
      exp_t e;
      if (bus0.i_ack) begin
         if (iQ.size() == 0) checkVal("i_unexpected_ack", 64'(bus0.i_ack), 64'd0);
         else begin
            e = iQ.pop_front();
            checkVal("i_ack_cycle", 64'(cyc), 64'(e.ackCyc));
            checkVal("i_rdata", bus0.i_rdata, e.rdata);
         end
      end
      if (bus0.d_ack) begin
         if (dQ.size() == 0) checkVal("d_unexpected_ack", 64'(bus0.d_ack), 64'd0);
         else begin
            e = dQ.pop_front();
            checkVal("d_ack_cycle", 64'(cyc), 64'(e.ackCyc));
            checkVal("d_rdata", bus0.d_rdata, e.rdata);
         end
      end
      if (bus1.i_ack) begin
         if (i1Q.size() == 0) checkVal("i1_unexpected_ack", 64'(bus1.i_ack), 64'd0);
         else begin
            e = i1Q.pop_front();
            checkVal("i1_ack_cycle", 64'(cyc), 64'(e.ackCyc));
            checkVal("i1_rdata", bus1.i_rdata, e.rdata);
         end
      end
      if (bus1.d_ack) checkVal("d1_unexpected_ack", 64'(bus1.d_ack), 64'd0);
   end

   initial begin
      int n;
      logic [63:0] iRd;
      logic [63:0] dRd;

      bus0.i_req = 1'b0; bus0.i_we = 1'b0; bus0.i_addr = '0; bus0.i_wdata = '0;
      bus0.d_req = 1'b0; bus0.d_we = 1'b0; bus0.d_addr = '0; bus0.d_wdata = '0;
      bus1.i_req = 1'b0; bus1.i_we = 1'b0; bus1.i_addr = '0; bus1.i_wdata = '0;
      bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
      iRd = '0;
      dRd = '0;

      // Reset state
      tick(2);
      checkVal("rst_busy", 64'(busy0), 64'd0);
      checkVal("rst_last_grant", 64'(lg0), 64'd0);
      checkVal("rst_mem_en", 64'(bus0.mem_en), 64'd0);
      checkVal("rst_mem_we", 64'(bus0.mem_we), 64'd0);
      checkVal("rst_mem_addr", 64'(bus0.mem_addr), 64'd0);
      checkVal("rst_i_rdata", bus0.i_rdata, 64'd0);
      checkVal("rst_d_rdata", bus0.d_rdata, 64'd0);
      rst = 1'b1;
      tick(1);

      // I read alone
      n = cyc;
      bus0.i_addr = 32'h100; bus0.i_we = 1'b0; bus0.i_req = 1'b1;
      iQ.push_back('{64'hDEAD_BEEF, n + 3});
      iRd = 64'hDEAD_BEEF;
      tick(1);
      checkVal("t1_mem_en_c1", 64'(bus0.mem_en), 64'd1);
      checkVal("t1_mem_addr", 64'(bus0.mem_addr), 64'h100);
      checkVal("t1_mem_we", 64'(bus0.mem_we), 64'd0);
      checkVal("t1_busy", 64'(busy0), 64'd1);
      tick(1);
      checkVal("t1_mem_en_c2", 64'(bus0.mem_en), 64'd1);
      tick(1);
      checkVal("t1_mem_en_c3", 64'(bus0.mem_en), 64'd0);
      bus0.i_req = 1'b0;
      tick(3);

      // D write alone
      n = cyc;
      bus0.d_addr = 32'h200; bus0.d_wdata = 64'h55; bus0.d_we = 1'b1; bus0.d_req = 1'b1;
      dQ.push_back('{dRd, n + 3});
      tick(1);
      checkVal("t2_mem_en", 64'(bus0.mem_en), 64'd1);
      checkVal("t2_mem_we_c1", 64'(bus0.mem_we), 64'd1);
      checkVal("t2_mem_addr", 64'(bus0.mem_addr), 64'h200);
      checkVal("t2_mem_wdata", bus0.mem_wdata, 64'h55);
      checkVal("t2_last_grant", 64'(lg0), 64'd1);
      tick(1);
      checkVal("t2_mem_we_c2", 64'(bus0.mem_we), 64'd1);
      tick(1);
      checkVal("t2_mem_we_c3", 64'(bus0.mem_we), 64'd0);
      checkVal("t2_i_rdata_kept", bus0.i_rdata, iRd);
      bus0.d_req = 1'b0; bus0.d_we = 1'b0;
      tick(3);

      // Both requesting from reset: D, I, D, I
      rst = 1'b0;
      tick(1);
      checkVal("t3_rst_last_grant", 64'(lg0), 64'd0);
      rst = 1'b1;
      n = cyc;
      bus0.i_addr = 32'h300; bus0.i_we = 1'b0; bus0.i_req = 1'b1;
      bus0.d_addr = 32'h400; bus0.d_we = 1'b0; bus0.d_req = 1'b1;
      dQ.push_back('{memData(32'h400), n + 3});
      iQ.push_back('{memData(32'h300), n + 7});
      dQ.push_back('{memData(32'h400), n + 11});
      iQ.push_back('{memData(32'h300), n + 15});
      for (int k = 0; k < 4; k++) begin
         tick((k == 0) ? 1 : 4);
         checkVal($sformatf("t3_last_grant_%0d", k), 64'(lg0), (k % 2 == 0) ? 64'd1 : 64'd0);
         checkVal($sformatf("t3_mem_addr_%0d", k), 64'(bus0.mem_addr),
                  (k % 2 == 0) ? 64'h400 : 64'h300);
      end
      tick(2);
      bus0.i_req = 1'b0; bus0.d_req = 1'b0;
      tick(3);

      // I held through its own ack: one masked IDLE cycle, then a fresh grant
      n = cyc;
      bus0.i_addr = 32'h500; bus0.i_req = 1'b1;
      iQ.push_back('{memData(32'h500), n + 3});
      iQ.push_back('{memData(32'h500), n + 8});
      tick(4);
      checkVal("t4_idle1_mem_en", 64'(bus0.mem_en), 64'd0);
      checkVal("t4_idle1_busy", 64'(busy0), 64'd0);
      tick(1);
      checkVal("t4_idle2_mem_en", 64'(bus0.mem_en), 64'd0);
      tick(1);
      checkVal("t4_regrant_mem_en", 64'(bus0.mem_en), 64'd1);
      tick(2);
      bus0.i_req = 1'b0;
      tick(4);

      // Reset during ACCESS aborts the access; the held req restarts from IDLE
      bus0.i_addr = 32'h600; bus0.i_req = 1'b1;
      tick(1);
      checkVal("t5_pre_mem_en", 64'(bus0.mem_en), 64'd1);
      #2 rst = 1'b0;
      #1;
      checkVal("t5_async_mem_en", 64'(bus0.mem_en), 64'd0);
      checkVal("t5_async_mem_we", 64'(bus0.mem_we), 64'd0);
      checkVal("t5_async_busy", 64'(busy0), 64'd0);
      checkVal("t5_async_i_ack", 64'(bus0.i_ack), 64'd0);
      tick(1);
      rst = 1'b1;
      n = cyc;
      iQ.push_back('{memData(32'h600), n + 3});
      tick(1);
      checkVal("t5_restart_c1", 64'(bus0.mem_en), 64'd1);
      checkVal("t5_restart_addr", 64'(bus0.mem_addr), 64'h600);
      tick(1);
      checkVal("t5_restart_c2", 64'(bus0.mem_en), 64'd1);
      tick(1);
      checkVal("t5_restart_c3", 64'(bus0.mem_en), 64'd0);
      bus0.i_req = 1'b0;
      tick(3);

      // MEM_LAT=1 read on the second instance
      n = cyc;
      bus1.i_addr = 32'h700; bus1.i_we = 1'b0; bus1.i_req = 1'b1;
      i1Q.push_back('{memData(32'h700), n + 2});
      tick(1);
      checkVal("t6_mem_en_c1", 64'(bus1.mem_en), 64'd1);
      checkVal("t6_mem_addr", 64'(bus1.mem_addr), 64'h700);
      tick(1);
      checkVal("t6_mem_en_c2", 64'(bus1.mem_en), 64'd0);
      bus1.i_req = 1'b0;
      tick(3);

      checkVal("end_i_pending", 64'(iQ.size()), 64'd0);
      checkVal("end_d_pending", 64'(dQ.size()), 64'd0);
      checkVal("end_i1_pending", 64'(i1Q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
